// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] PC_INCR = 32'(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and instruction register handshakes
interface instr_fetch_unit_if;
    import mips_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_instr;
    logic [31:0]        ir_pc;
    logic [31:0]        ir_pc_plus4;

    modport master (
        output imem_req, imem_addr, ir_valid, ir_instr, ir_pc, ir_pc_plus4,
        input  imem_ack, imem_rdata, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc, ir_pc_plus4,
        output imem_ack, imem_rdata, ir_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// rtl/instr_fetch_unit_fetch_queue.sv - prefetch FIFO of {instr, pc} with flush
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is cleared on reset so the head reads as pc=0/instr=0 when empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

    assert property (@(posedge CLK) disable iff (RESET) !(pop && count == '0));
    assert property (@(posedge CLK) disable iff (RESET) !(push && count == FULL));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, imem request FSM and prefetch queue
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    instr_fetch_unit_if.master     bus,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t state, state_n;
    logic         req_q, req_n;
    logic [31:0]  addr_q, addr_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic         ack, push, pop;
    logic [CW-1:0] count_n;
    fetch_entry_t head;

    assign ack     = req_q && bus.imem_ack;
    assign push    = (state == WAIT) && ack && !redirect;
    assign pop     = bus.ir_valid && bus.ir_ready && !redirect;
    assign count_n = queue_count + CW'(push) - CW'(pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            addr_q   <= addr_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // A request is only issued when the post-edge occupancy leaves a free
    // slot, so the response can always be pushed.
    always_comb begin
        state_n    = state;
        req_n      = req_q;
        addr_n     = addr_q;
        fetch_pc_n = fetch_pc;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_n = word_align(redirect_pc);
                end else if (count_n < FULL) begin
                    state_n = WAIT;
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_n = word_align(redirect_pc);
                    if (ack) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (ack) begin
                    fetch_pc_n = fetch_pc + PC_INCR;
                    if (count_n < FULL) begin
                        addr_n = fetch_pc + PC_INCR;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_n = word_align(redirect_pc);
                end
                if (ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data ({bus.imem_rdata, addr_q}),
        .head      (head),
        .count     (queue_count)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.ir_valid    = (queue_count != '0);
    assign bus.ir_instr    = head.instr;
    assign bus.ir_pc       = head.pc;
    assign bus.ir_pc_plus4 = head.pc + PC_INCR;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  queue_count;

    logic        mem_en;
    logic        force_ack;
    int          lat;
    int          wait_cnt;
    int          ack_cnt;
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .queue_count (queue_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0000_0020;
            32'h4:   return 32'h0064_2824;
            32'h8:   return 32'hDEAD_BEEF;
            default: return 32'hC000_0000 | addr;
        endcase
    endfunction

    always_comb begin
        bus.imem_ack   = force_ack || (mem_en && bus.imem_req && (wait_cnt >= lat));
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    always @(posedge CLK) begin
        if (RESET || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (RESET) ack_cnt <= 0;
        else if (bus.imem_req && bus.imem_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        redirect  = 1'b0;
        force_ack = 1'b0;
        step(2);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_en = 1'b1; force_ack = 1'b0; lat = 0; bus.ir_ready = 1'b1;

        // Reset values, then zero-wait free run
        step(2);
        check("rst_req",   bus.imem_req, 0);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", bus.ir_valid, 0);
        check("rst_instr", bus.ir_instr, 32'h0);
        check("rst_pc",    bus.ir_pc, 32'h0);
        check("rst_pc4",   bus.ir_pc_plus4, 32'h4);
        check("rst_count", queue_count, 0);
        RESET = 1'b0;
        step();
        check("fr_req0",  bus.imem_req, 1);
        check("fr_addr0", bus.imem_addr, 32'h0);
        step();
        check("fr_addr1",  bus.imem_addr, 32'h4);
        check("fr_valid1", bus.ir_valid, 1);
        check("fr_instr1", bus.ir_instr, 32'h0000_0020);
        check("fr_pc1",    bus.ir_pc, 32'h0);
        check("fr_pc4_1",  bus.ir_pc_plus4, 32'h4);
        step();
        check("fr_addr2",  bus.imem_addr, 32'h8);
        check("fr_instr2", bus.ir_instr, 32'h0064_2824);
        check("fr_pc2",    bus.ir_pc, 32'h4);
        check("fr_pc4_2",  bus.ir_pc_plus4, 32'h8);

        // Backpressure: fill to DEPTH, single pop, refill, in-order drain
        bus.ir_ready = 1'b0;
        do_reset();
        step(8);
        check("bp_acks",  ack_cnt, 4);
        check("bp_count", queue_count, 4);
        check("bp_req",   bus.imem_req, 0);
        check("bp_pc0",   bus.ir_pc, 32'h0);
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        check("bp_count3", queue_count, 3);
        check("bp_req1",   bus.imem_req, 1);
        check("bp_addr10", bus.imem_addr, 32'h10);
        step();
        check("bp_count4", queue_count, 4);
        check("bp_req2",   bus.imem_req, 0);
        check("bp_acks5",  ack_cnt, 5);
        mem_en = 1'b0;
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_order", bus.ir_pc, 32'(4 + 4 * i));
            step();
        end

        // Slow memory: ack in the 4th cycle of each request
        mem_en = 1'b1; lat = 3; bus.ir_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("sl_req",   bus.imem_req, 1);
            check("sl_addr",  bus.imem_addr, 32'h0);
            check("sl_valid", bus.ir_valid, 0);
        end
        step();
        check("sl_valid_ack", bus.ir_valid, 0);
        step();
        check("sl_valid_up", bus.ir_valid, 1);
        check("sl_pc0",      bus.ir_pc, 32'h0);
        check("sl_addr4",    bus.imem_addr, 32'h4);
        step(3);
        check("sl_count1", queue_count, 1);
        check("sl_addr4b", bus.imem_addr, 32'h4);
        step();
        check("sl_count2", queue_count, 2);

        // Redirect while a request is outstanding: response must be dropped
        lat = 0; mem_en = 1'b1; bus.ir_ready = 1'b1;
        do_reset();
        step(3);
        check("rw_addr8", bus.imem_addr, 32'h8);
        mem_en = 1'b0;
        step();
        check("rw_hold", bus.imem_addr, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h24;
        step();
        redirect = 1'b0;
        check("rw_count",  queue_count, 0);
        check("rw_valid",  bus.ir_valid, 0);
        check("rw_daddr",  bus.imem_addr, 32'h8);
        check("rw_dreq",   bus.imem_req, 1);
        step();
        mem_en = 1'b1;
        check("rw_valid2", bus.ir_valid, 0);
        step();
        check("rw_valid3", bus.ir_valid, 0);
        check("rw_req0",   bus.imem_req, 0);
        step();
        check("rw_addr24", bus.imem_addr, 32'h24);
        check("rw_req1",   bus.imem_req, 1);
        step();
        check("rw_nvalid", bus.ir_valid, 1);
        check("rw_npc",    bus.ir_pc, 32'h24);
        check("rw_ninstr", bus.ir_instr, 32'hC000_0024);

        // Redirect coinciding with ack and pop, unaligned target
        do_reset();
        step(2);
        check("ra_valid", bus.ir_valid, 1);
        redirect = 1'b1; redirect_pc = 32'h1E;
        step();
        redirect = 1'b0;
        check("ra_valid0", bus.ir_valid, 0);
        check("ra_count0", queue_count, 0);
        check("ra_req0",   bus.imem_req, 0);
        step();
        check("ra_addr1c", bus.imem_addr, 32'h1C);
        check("ra_req1",   bus.imem_req, 1);
        step();
        check("ra_pc1c",   bus.ir_pc, 32'h1C);

        // Asynchronous reset with three queued words and a request pending
        bus.ir_ready = 1'b0;
        do_reset();
        step(4);
        check("ar_count3", queue_count, 3);
        check("ar_addrc",  bus.imem_addr, 32'hC);
        mem_en = 1'b0;
        #2;
        RESET = 1'b1; force_ack = 1'b1; mem_en = 1'b1;
        #1;
        check("ar_req",   bus.imem_req, 0);
        check("ar_addr",  bus.imem_addr, 32'h0);
        check("ar_valid", bus.ir_valid, 0);
        check("ar_count", queue_count, 0);
        check("ar_pc",    bus.ir_pc, 32'h0);
        check("ar_pc4",   bus.ir_pc_plus4, 32'h4);
        check("ar_instr", bus.ir_instr, 32'h0);
        step();
        check("ar_count_hold", queue_count, 0);
        check("ar_req_hold",   bus.imem_req, 0);
        RESET = 1'b0; force_ack = 1'b0;
        step();
        check("ar_req1",  bus.imem_req, 1);
        check("ar_addr0", bus.imem_addr, 32'h0);
        check("ar_cnt0",  queue_count, 0);
        step();
        check("ar_cnt1",  queue_count, 1);
        check("ar_pc0",   bus.ir_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
